// File: rtl/sdram_stream_master.sv
// rtl/sdram_stream_master.sv - Avalon-MM master that captures a sample stream to SDRAM and plays it back
module sdram_stream_master #(
    parameter int FIFO_DEPTH    = 16,
    parameter int MAX_PENDING   = 4,
    parameter int RD_DATA_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_mode,
    input  logic [24:0] cmd_addr,
    input  logic [24:0] cmd_len,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        chipselect,
    output logic        write_n,
    output logic        read_n,
    output logic [1:0]  byteenable_n,
    output logic [24:0] address,
    output logic [15:0] write_data,
    input  logic [15:0] read_data,
    input  logic        wait_request,
    input  logic        data_validation
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
    localparam logic [3:0]  MAX_P = MAX_PENDING[3:0];

    typedef enum logic [1:0] {IDLE, CAPTURE, PLAY_ISSUE, PLAY_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [24:0] addr_q, addr_d, len_q, len_d;
    logic [24:0] xfer_q, xfer_d, push_cnt_q, push_cnt_d, rx_q, rx_d;
    logic [3:0]  pend_q, pend_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        done_q, done_d, ovf_q, ovf_d;
    logic [15:0] out_data_q;
    logic        out_valid_q;
    logic [15:0] fifo_mem [FIFO_DEPTH];

    logic [AW:0] fifo_cnt;
    logic        fifo_empty, fifo_full;
    logic        wr_req, rd_req, wr_acc, rd_acc;
    logic        push_req, push, dv_acc, rd_strobe;

    assign fifo_cnt   = wptr_q - rptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH);
    assign wr_req     = (state_q == CAPTURE) && !fifo_empty;
    assign rd_req     = (state_q == PLAY_ISSUE) && (pend_q < MAX_P);
    assign wr_acc     = wr_req && !wait_request;
    assign rd_acc     = rd_req && !wait_request;
    // A full FIFO still takes the sample when its head leaves in the same cycle
    assign push_req   = (state_q == CAPTURE) && in_valid && (push_cnt_q != len_q);
    assign push       = push_req && (!fifo_full || wr_acc);
    assign dv_acc     = data_validation && (pend_q != 4'd0);

    if (RD_DATA_DELAY == 0) begin : g_no_dly
        assign rd_strobe = dv_acc;
    end else begin : g_dly
        logic [RD_DATA_DELAY-1:0] dly_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= dv_acc;
                for (int i = 1; i < RD_DATA_DELAY; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
        assign rd_strobe = dly_q[RD_DATA_DELAY-1];
    end

    assign chipselect   = wr_req || rd_req;
    assign write_n      = !wr_req;
    assign read_n       = !rd_req;
    assign byteenable_n = 2'b00;
    assign address      = addr_q;
    assign write_data   = wr_req ? fifo_mem[rptr_q[AW-1:0]] : 16'h0000;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        xfer_d     = xfer_q;
        push_cnt_d = push ? push_cnt_q + 25'd1 : push_cnt_q;
        rx_d       = rd_strobe ? rx_q + 25'd1 : rx_q;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = wr_acc ? rptr_q + 1'b1 : rptr_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q | (push_req && !push);
        pend_d     = pend_q;
        if (rd_acc && !dv_acc) begin
            pend_d = pend_q + 4'd1;
        end else if (!rd_acc && dv_acc) begin
            pend_d = pend_q - 4'd1;
        end
        if (wr_acc || rd_acc) begin
            addr_d = addr_q + 25'd1;
            xfer_d = xfer_q + 25'd1;
        end
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    xfer_d     = '0;
                    push_cnt_d = '0;
                    rx_d       = '0;
                    wptr_d     = '0;
                    rptr_d     = '0;
                    ovf_d      = 1'b0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = cmd_mode ? PLAY_ISSUE : CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (wr_acc && (xfer_q + 25'd1 == len_q)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            PLAY_ISSUE: begin
                if (rd_acc && (xfer_q + 25'd1 == len_q)) begin
                    state_d = PLAY_DRAIN;
                end
            end
            PLAY_DRAIN: begin
                // rx_q counts delayed strobes, so it reaches len_q as the last word is shown
                if (out_valid_q && (rx_q == len_q)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            xfer_q      <= '0;
            push_cnt_q  <= '0;
            rx_q        <= '0;
            pend_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            xfer_q      <= xfer_d;
            push_cnt_q  <= push_cnt_d;
            rx_q        <= rx_d;
            pend_q      <= pend_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            out_valid_q <= rd_strobe;
            if (rd_strobe) begin
                out_data_q <= read_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule
